// File: rtl/uart_tx_scheduler.sv
// Turns game events into a queued ASCII byte stream for uart_tx.
// Optional macro UART_SCORE_REPORT_EN appends the two score digits and a newline after "R".
//
// state     | meaning
// IDLE      | waiting for a queued byte and a free uart_tx
// WAIT_ACK  | tx_start issued, waiting for tx_busy to rise (bounded by ACK_TIMEOUT)
// WAIT_DONE | uart_tx busy with the byte, waiting for tx_busy to fall
module uart_tx_scheduler #(
    parameter int DEPTH       = 8,
    parameter int ACK_TIMEOUT = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [4:0]               mole_position,
    input  logic                     game_active,
    input  logic                     game_finish,
    input  logic                     game_start,
    input  logic [7:0]               score_bcd,
    input  logic                     tx_busy,
    output logic                     tx_start,
    output logic [7:0]               tx_data,
    output logic [$clog2(DEPTH):0]   fifo_level,
    output logic                     overflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_ACK  = 2'd1;
    localparam logic [1:0] WAIT_DONE = 2'd2;

    logic [1:0]    state;
    logic [TW-1:0] timer;

    logic [4:0] last_pos;
    logic       pend_mole;
    logic [2:0] pend_idx;
    logic       pend_over;
    logic       finish_d;

    logic       mole_onehot;
    logic       mole_event;
    logic [2:0] mole_idx;
    logic       finish_rise;

    logic       wr_en;
    logic [7:0] wr_data;
    logic       over_wr;
    logic       mole_wr;

    logic [7:0]    mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;

`ifdef UART_SCORE_REPORT_EN
    logic [1:0] burst_left;
    logic [7:0] score_q;
    logic       burst_wr;
`else
    logic       unused_score;
    assign unused_score = ^score_bcd;
`endif

    assign mole_onehot = (mole_position != 5'd0) &&
                         ((mole_position & (mole_position - 5'd1)) == 5'd0);
    assign mole_event  = game_active && mole_onehot && (mole_position != last_pos);
    assign finish_rise = game_finish && !finish_d;

    always_comb begin
        mole_idx = 3'd0;
        case (mole_position)
            5'b00001: mole_idx = 3'd0;
            5'b00010: mole_idx = 3'd1;
            5'b00100: mole_idx = 3'd2;
            5'b01000: mole_idx = 3'd3;
            5'b10000: mole_idx = 3'd4;
            default:  mole_idx = 3'd0;
        endcase
    end

    // One write slot per cycle: game over, then any score burst, then the latest mole.
    always_comb begin
        wr_en   = 1'b0;
        wr_data = 8'h00;
        over_wr = 1'b0;
        mole_wr = 1'b0;
`ifdef UART_SCORE_REPORT_EN
        burst_wr = 1'b0;
`endif
        if (pend_over) begin
            wr_en   = 1'b1;
            wr_data = 8'h52;
            over_wr = 1'b1;
        end
`ifdef UART_SCORE_REPORT_EN
        else if (burst_left != 2'd0) begin
            wr_en    = 1'b1;
            burst_wr = 1'b1;
            case (burst_left)
                2'd3:    wr_data = 8'h30 + {4'h0, score_q[7:4]};
                2'd2:    wr_data = 8'h30 + {4'h0, score_q[3:0]};
                default: wr_data = 8'h0A;
            endcase
        end
`endif
        else if (pend_mole) begin
            wr_en   = 1'b1;
            wr_data = 8'h30 + {5'd0, pend_idx};
            mole_wr = 1'b1;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_pos  <= 5'd0;
            pend_mole <= 1'b0;
            pend_idx  <= 3'd0;
            pend_over <= 1'b0;
            finish_d  <= 1'b0;
        end else begin
            finish_d <= game_finish;
            if (!game_active)
                last_pos <= 5'd0;
            else if (mole_event)
                last_pos <= mole_position;
            if (mole_event) begin
                pend_mole <= 1'b1;
                pend_idx  <= mole_idx;
            end else if (mole_wr) begin
                pend_mole <= 1'b0;
            end
            if (finish_rise)
                pend_over <= 1'b1;
            else if (over_wr)
                pend_over <= 1'b0;
        end
    end

`ifdef UART_SCORE_REPORT_EN
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            burst_left <= 2'd0;
            score_q    <= 8'h00;
        end else begin
            if (finish_rise)
                score_q <= score_bcd;
            if (over_wr)
                burst_left <= 2'd3;
            else if (burst_wr)
                burst_left <= burst_left - 2'd1;
        end
    end
`endif

    assign full = (count == (AW+1)'(DEPTH));
    assign pop  = (state == IDLE) && (count != '0) && !tx_busy;
    // A pop in the same cycle frees the slot, so a push to a full FIFO is still accepted.
    assign push = wr_en && (!full || pop);
    assign drop = wr_en && full && !pop;

    always_ff @(posedge clock) begin
        if (push)
            mem[wr_ptr] <= wr_data;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push)
                wr_ptr <= wr_ptr + 1'b1;
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (push && !pop)
                count <= count + 1'b1;
            else if (pop && !push)
                count <= count - 1'b1;
            if (drop)
                overflow <= 1'b1;
            else if (game_start)
                overflow <= 1'b0;
        end
    end

    assign fifo_level = count;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            timer    <= '0;
            tx_start <= 1'b0;
            tx_data  <= 8'h00;
        end else begin
            tx_start <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        tx_data  <= mem[rd_ptr];
                        tx_start <= 1'b1;
                        timer    <= TW'(ACK_TIMEOUT - 1);
                        state    <= WAIT_ACK;
                    end
                end
                WAIT_ACK: begin
                    if (tx_busy)
                        state <= WAIT_DONE;
                    else if (timer == '0)
                        state <= IDLE;
                    else
                        timer <= timer - 1'b1;
                end
                WAIT_DONE: begin
                    if (!tx_busy)
                        state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Directed bench for uart_tx_scheduler with a small uart_tx busy model and a byte monitor.
module tb_uart_tx_scheduler;

    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [4:0] mole_position = 5'd0;
    logic       game_active = 1'b0;
    logic       game_finish = 1'b0;
    logic       game_start = 1'b0;
    logic [7:0] score_bcd = 8'h00;
    logic       tx_busy = 1'b0;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [3:0] fifo_level;
    logic       overflow;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    logic busy_hold = 1'b0;
    logic auto_en = 1'b1;
    int   bcnt = 0;

    logic [7:0] sent_q[$];
    int         sent_t[$];

    uart_tx_scheduler #(.DEPTH(8), .ACK_TIMEOUT(16)) dut (
        .clock(clock),
        .reset(reset),
        .mole_position(mole_position),
        .game_active(game_active),
        .game_finish(game_finish),
        .game_start(game_start),
        .score_bcd(score_bcd),
        .tx_busy(tx_busy),
        .tx_start(tx_start),
        .tx_data(tx_data),
        .fifo_level(fifo_level),
        .overflow(overflow)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc = cyc + 1;

    // uart_tx stand-in: busy for four half-offset cycles after each tx_start, or held by the bench.
    always @(negedge clock) begin
        if (tx_start && auto_en)
            bcnt = 4;
        else if (bcnt > 0)
            bcnt = bcnt - 1;
        tx_busy = busy_hold || (bcnt > 0);
        if (tx_start) begin
            sent_q.push_back(tx_data);
            sent_t.push_back(cyc);
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #2;
    endtask

    function automatic logic [7:0] sent_byte(input int i);
        if (i < sent_q.size()) return sent_q[i];
        return 8'hFF;
    endfunction

    function automatic int sent_gap(input int i);
        if (i + 1 < sent_t.size()) return sent_t[i+1] - sent_t[i];
        return -1;
    endfunction

    logic [4:0] burst_pos [10] = '{5'd1, 5'd2, 5'd4, 5'd16, 5'd1, 5'd2, 5'd4, 5'd16, 5'd1, 5'd2};
    logic [7:0] burst_exp [8]  = '{8'h30, 8'h31, 8'h32, 8'h34, 8'h30, 8'h31, 8'h32, 8'h34};
`ifdef UART_SCORE_REPORT_EN
    logic [7:0] over_exp [5] = '{8'h52, 8'h32, 8'h37, 8'h0A, 8'h32};
    localparam int OVER_N = 5;
`else
    logic [7:0] over_exp [2] = '{8'h52, 8'h32};
    localparam int OVER_N = 2;
`endif

    initial begin
        // Test 1: reset values and single-mole latency
        repeat (2) step();
        check("rst_tx_start", tx_start, 0);
        check("rst_tx_data", tx_data, 8'h00);
        check("rst_fifo_level", fifo_level, 0);
        check("rst_overflow", overflow, 0);
        reset = 1'b1;
        game_active = 1'b1;
        repeat (2) step();
        mole_position = 5'b00100;
        step();
        check("t1_level_n", fifo_level, 0);
        step();
        check("t1_level_n1", fifo_level, 1);
        check("t1_start_n1", tx_start, 0);
        step();
        check("t1_start_n2", tx_start, 1);
        check("t1_data", tx_data, 8'h32);
        check("t1_level_n2", fifo_level, 0);
        step();
        check("t1_start_pulse", tx_start, 0);
        repeat (10) step();
        check("t1_count", sent_q.size(), 1);

        // Test 2: three moles queued behind a busy uart, sent in order with idle gap
        sent_q.delete(); sent_t.delete();
        busy_hold = 1'b1;
        step();
        mole_position = 5'b00001; step();
        mole_position = 5'b00010; step();
        mole_position = 5'b01000; step();
        repeat (3) step();
        check("t2_level", fifo_level, 3);
        check("t2_none_sent", sent_q.size(), 0);
        busy_hold = 1'b0;
        repeat (30) step();
        check("t2_count", sent_q.size(), 3);
        check("t2_b0", sent_byte(0), 8'h30);
        check("t2_b1", sent_byte(1), 8'h31);
        check("t2_b2", sent_byte(2), 8'h33);
        check("t2_gap0", sent_gap(0), 6);
        check("t2_gap1", sent_gap(1), 6);

        // Test 3: overflow on a full FIFO, cleared by game_start
        sent_q.delete(); sent_t.delete();
        busy_hold = 1'b1;
        step();
        for (int i = 0; i < 10; i++) begin
            mole_position = burst_pos[i];
            step();
        end
        repeat (3) step();
        check("t3_level_full", fifo_level, 8);
        check("t3_overflow", overflow, 1);
        game_start = 1'b1; step();
        game_start = 1'b0; step();
        check("t3_overflow_clr", overflow, 0);
        check("t3_level_kept", fifo_level, 8);
        busy_hold = 1'b0;
        repeat (70) step();
        check("t3_count", sent_q.size(), 8);
        for (int i = 0; i < 8; i++)
            check($sformatf("t3_b%0d", i), sent_byte(i), burst_exp[i]);

        // Non-one-hot position is ignored; leaving RUNNING re-arms the same mole
        mole_position = 5'b00011;
        repeat (4) step();
        check("nonhot_level", fifo_level, 0);
        check("nonhot_count", sent_q.size(), 8);
        mole_position = 5'b00010;
        game_active = 1'b0;
        repeat (2) step();
        game_active = 1'b1;
        repeat (4) step();
        check("rearm_count", sent_q.size(), 9);
        check("rearm_byte", sent_byte(8), 8'h31);
        repeat (10) step();

        // Test 4: game over and mole change in the same cycle
        sent_q.delete(); sent_t.delete();
        score_bcd = 8'h27;
        mole_position = 5'b00100;
        game_finish = 1'b1;
        step();
        repeat (40) step();
        check("t4_count", sent_q.size(), OVER_N);
        for (int i = 0; i < OVER_N; i++)
            check($sformatf("t4_b%0d", i), sent_byte(i), over_exp[i]);
        game_finish = 1'b0;
        step();

        // Test 5: uart never acknowledges, scheduler times out and moves on
        sent_q.delete(); sent_t.delete();
        auto_en = 1'b0;
        mole_position = 5'b00001; step();
        mole_position = 5'b00010; step();
        repeat (45) step();
        check("t5_count", sent_q.size(), 2);
        check("t5_b0", sent_byte(0), 8'h30);
        check("t5_b1", sent_byte(1), 8'h31);
        check("t5_gap", sent_gap(0), 17);
        auto_en = 1'b1;

        // Test 6: reset in WAIT_DONE with three bytes queued
        sent_q.delete(); sent_t.delete();
        mole_position = 5'b00001; step();
        mole_position = 5'b00010; step();
        mole_position = 5'b00100; step();
        busy_hold = 1'b1;
        mole_position = 5'b01000; step();
        repeat (4) step();
        check("t6_level_before", fifo_level, 3);
        check("t6_sent_before", sent_q.size(), 1);
        mole_position = 5'b00000;
        reset = 1'b0;
        #1;
        check("t6_level_rst", fifo_level, 0);
        check("t6_start_rst", tx_start, 0);
        repeat (3) step();
        reset = 1'b1;
        busy_hold = 1'b0;
        repeat (30) step();
        check("t6_sent_after", sent_q.size(), 1);
        check("t6_level_after", fifo_level, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
